// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: branch opcode/funct3 codes and the redirect FSM state type.
package rv32_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int unsigned BIMM_W = 12;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } redir_state_t;

    // True when the opcode field names a conditional branch.
    function automatic logic is_branch_opc(input logic [6:0] opc);
        return opc == OPC_BRANCH;
    endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Combinational branch target: pc + sext({imm,0}), plus a flag for non word-aligned targets.
module branch_target_calc
    import rv32_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]   pc,
    input  logic [BIMM_W-1:0] imm,
    output logic [XLEN-1:0]   target,
    output logic              misalign
);

    localparam int unsigned OFF_W = BIMM_W + 1;

    logic [XLEN-1:0] offset;

    // imm holds bits [12:1]; bit 0 of a B-type offset is always zero.
    assign offset   = {{(XLEN-OFF_W){imm[BIMM_W-1]}}, imm, 1'b0};
    assign target   = pc + offset;
    assign misalign = |target[1:0];

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Turns a resolved taken branch into a held PC redirect request plus wrong-path flushes,
// and keeps resolved/taken branch statistics.
module branch_redirect_ctrl
    import rv32_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_is_branch,
    input  logic              ex_taken,
    input  logic              stall_ex,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic [11:0]       ex_imm,
    input  logic              redirect_ready,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              misalign_err,
    output logic              busy,
    output logic [CNT_W-1:0]  branch_count,
    output logic [CNT_W-1:0]  taken_count
);

    localparam int unsigned DW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

    redir_state_t    state;
    logic [DW-1:0]   drain_cnt;
    logic [XLEN-1:0] target;
    logic            target_misalign;
    logic            resolve;

    branch_target_calc #(
        .XLEN (XLEN)
    ) u_target (
        .pc       (ex_pc),
        .imm      (ex_imm),
        .target   (target),
        .misalign (target_misalign)
    );

    assign resolve = ex_valid & ex_is_branch & ~stall_ex;

    // Redirect sequencing; branches seen outside IDLE are wrong-path and dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            drain_cnt    <= '0;
            redirect_pc  <= '0;
            misalign_err <= 1'b0;
            branch_count <= '0;
            taken_count  <= '0;
        end else begin
            misalign_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (resolve) begin
                        branch_count <= branch_count + CNT_W'(1);
                        if (ex_taken) begin
                            taken_count <= taken_count + CNT_W'(1);
                            if (target_misalign) begin
                                misalign_err <= 1'b1;
                            end else begin
                                redirect_pc <= target;
                                state       <= REDIRECT;
                            end
                        end
                    end
                end
                REDIRECT: begin
                    if (redirect_ready) begin
                        if (FLUSH_CYCLES == 0) begin
                            state <= IDLE;
                        end else begin
                            state     <= DRAIN;
                            drain_cnt <= DW'(FLUSH_CYCLES);
                        end
                    end
                end
                DRAIN: begin
                    // Extra IF/ID squash cycles cover instructions already in flight from IMEM.
                    if (drain_cnt <= DW'(1)) begin
                        state <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign redirect_valid = (state == REDIRECT);
    assign flush_idex     = (state == REDIRECT);
    assign flush_ifid     = (state != IDLE);
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural redirect model.
module tb_branch_redirect_ctrl;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned FLUSH = 1;
    localparam int unsigned CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             ex_valid, ex_is_branch, ex_taken, stall_ex, redirect_ready;
    logic [XLEN-1:0]  ex_pc;
    logic [11:0]      ex_imm;
    logic             redirect_valid, flush_ifid, flush_idex, misalign_err, busy;
    logic [XLEN-1:0]  redirect_pc;
    logic [CNT_W-1:0] branch_count, taken_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a pending redirect flag, a count of remaining drain cycles.
    bit              m_pending;
    int              m_drain;
    logic [XLEN-1:0] m_pc;
    bit              m_mis;
    logic [CNT_W-1:0] m_bc, m_tc;

    always #5 clk = ~clk;

    branch_redirect_ctrl #(
        .XLEN         (XLEN),
        .FLUSH_CYCLES (FLUSH),
        .CNT_W        (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_taken       (ex_taken),
        .stall_ex       (stall_ex),
        .ex_pc          (ex_pc),
        .ex_imm         (ex_imm),
        .redirect_ready (redirect_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_ifid     (flush_ifid),
        .flush_idex     (flush_idex),
        .misalign_err   (misalign_err),
        .busy           (busy),
        .branch_count   (branch_count),
        .taken_count    (taken_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] ref_target(input logic [XLEN-1:0] pc, input logic [11:0] imm);
        logic signed [11:0] s;
        s = imm;
        return pc + XLEN'(int'(s) * 2);
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        logic [XLEN-1:0] t;
        bit mis_next;
        mis_next = 0;
        if (rst) begin
            m_pending = 0; m_drain = 0; m_pc = '0; m_bc = '0; m_tc = '0;
        end else if (!m_pending && m_drain == 0) begin
            if (ex_valid && ex_is_branch && !stall_ex) begin
                m_bc = m_bc + 1;
                if (ex_taken) begin
                    m_tc = m_tc + 1;
                    t = ref_target(ex_pc, ex_imm);
                    if (t % 4 == 0) begin
                        m_pending = 1;
                        m_pc = t;
                    end else begin
                        mis_next = 1;
                    end
                end
            end
        end else if (m_pending) begin
            if (redirect_ready) begin
                m_pending = 0;
                m_drain = FLUSH;
            end
        end else begin
            m_drain--;
        end
        m_mis = mis_next;
    endtask

    task automatic check_all();
        check("redirect_valid", 64'(redirect_valid), 64'(m_pending));
        check("flush_idex",     64'(flush_idex),     64'(m_pending));
        check("flush_ifid",     64'(flush_ifid),     64'(m_pending || m_drain > 0));
        check("busy",           64'(busy),           64'(m_pending || m_drain > 0));
        check("misalign_err",   64'(misalign_err),   64'(m_mis));
        check("redirect_pc",    64'(redirect_pc),    64'(m_pc));
        check("branch_count",   64'(branch_count),   64'(m_bc));
        check("taken_count",    64'(taken_count),    64'(m_tc));
    endtask

    // Inputs are driven just after a falling edge; outputs are checked on the next falling edge.
    task automatic cycle();
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input bit r, input bit v, input bit br, input bit tk, input bit st,
                         input logic [31:0] pc, input logic [11:0] imm, input bit rdy);
        rst = r; ex_valid = v; ex_is_branch = br; ex_taken = tk; stall_ex = st;
        ex_pc = pc; ex_imm = imm; redirect_ready = rdy;
        cycle();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 32'h0, 12'h0, rdy);
    endtask

    initial begin
        m_pending = 0; m_drain = 0; m_pc = '0; m_mis = 0; m_bc = '0; m_tc = '0;
        rst = 1'b1; ex_valid = 0; ex_is_branch = 0; ex_taken = 0; stall_ex = 0;
        ex_pc = '0; ex_imm = '0; redirect_ready = 0;
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 32'h0, 12'h0, 0);
        drive(1, 0, 0, 0, 0, 32'h0, 12'h0, 0);

        // T1: taken +16 from 0x100, fetch ready immediately
        drive(0, 1, 1, 1, 0, 32'h100, 12'h008, 1);
        check("t1_pc", 64'(redirect_pc), 64'h110);
        check("t1_rv", 64'(redirect_valid), 64'h1);
        idle(1, 1);
        check("t1_drain_idex", 64'(flush_idex), 64'h0);
        check("t1_drain_ifid", 64'(flush_ifid), 64'h1);
        idle(2, 1);

        // T2: same branch, fetch stalls for three cycles
        drive(0, 1, 1, 1, 0, 32'h100, 12'h008, 0);
        idle(3, 0);
        check("t2_hold_pc", 64'(redirect_pc), 64'h110);
        idle(1, 1);
        idle(2, 1);

        // T3: backward wrap, then misaligned target
        drive(0, 1, 1, 1, 0, 32'h0, 12'hFFE, 1);
        check("t3_wrap", 64'(redirect_pc), 64'hFFFF_FFFC);
        idle(3, 1);
        drive(0, 1, 1, 1, 0, 32'h100, 12'h001, 1);
        check("t3_mis", 64'(misalign_err), 64'h1);
        idle(2, 1);

        // T4: not-taken branch held by stall_ex, counted once
        drive(0, 1, 1, 0, 1, 32'h200, 12'h010, 1);
        drive(0, 1, 1, 1, 1, 32'h200, 12'h010, 1);
        drive(0, 1, 1, 0, 0, 32'h200, 12'h010, 1);
        idle(1, 1);

        // T5: second taken branch during REDIRECT is wrong-path
        drive(0, 1, 1, 1, 0, 32'h400, 12'h010, 0);
        drive(0, 1, 1, 1, 0, 32'h800, 12'h020, 0);
        check("t5_keep_pc", 64'(redirect_pc), 64'h420);
        idle(3, 1);

        // T6: reset mid-REDIRECT, then a fresh redirect
        drive(0, 1, 1, 1, 0, 32'h1000, 12'h004, 0);
        drive(1, 0, 0, 0, 0, 32'h0, 12'h0, 0);
        check("t6_busy", 64'(busy), 64'h0);
        drive(0, 1, 1, 1, 0, 32'h2000, 12'h7FC, 1);
        idle(3, 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] pc;
            pc = $urandom;
            if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                  $urandom_range(0, 1) == 1, ($urandom_range(0, 4) == 0), pc,
                  12'($urandom), ($urandom_range(0, 2) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
